wb_ctrl: RTL
============

WB_CTRL -- requirements
Module: wb_ctrl

Interface
REQ-001 The block SHALL have exactly one clock, clk, and reset SHALL be synchronous and active-high, named reset.
REQ-002 Ports SHALL be as follows:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result available
- alu_ready  out  1  ALU result accepted this cycle
- alu_rdadr  in  4  ALU destination register
- alu_data  in  32  ALU result
- ld_issue_valid  in  1  load issued to memory
- ld_issue_ready  out  1  load issue accepted
- ld_issue_rdadr  in  4  load destination register
- ld_rsp_valid  in  1  load data returned
- ld_rsp_ready  out  1  load data accepted
- ld_rsp_data  in  32  load data
- rs1adr, rs2adr  in  4 each  decode source registers
- stall  out  1  decode must hold
- regwrite  out  1  register-file write enable
- rdadr  out  4  register-file write address
- rd  out  32  register-file write data

Function
REQ-003 A 16-bit scoreboard SHALL mark registers with an outstanding load; bit 0 SHALL never be set.
REQ-004 An in-order load-tag queue SHALL hold 2 entries of 4-bit rdadr.
REQ-005 A load issue SHALL be accepted when ld_issue_valid && ld_issue_ready; it pushes ld_issue_rdadr and sets the scoreboard bit on the next edge.
REQ-006 ld_issue_ready SHALL = queue not full && scoreboard[ld_issue_rdadr]==0; a same-cycle pop SHALL NOT free a slot for a push.
REQ-007 ld_rsp_ready SHALL = queue not empty; a response with an empty queue SHALL be ignored.
REQ-008 Load response SHALL have priority: alu_ready SHALL = !(ld_rsp_valid && ld_rsp_ready) && scoreboard[alu_rdadr]==0 (WAW guard).
REQ-009 An accepted response SHALL pop the queue head, clear its scoreboard bit, and register regwrite=1, rdadr=head, rd=ld_rsp_data.
REQ-010 An accepted ALU result SHALL register regwrite=1, rdadr=alu_rdadr, rd=alu_data.
REQ-011 Write latency SHALL be exactly 1 cycle from acceptance to regwrite high; regwrite SHALL be 0 in cycles with no acceptance, and rdadr/rd SHALL then hold their values.
REQ-012 A write targeting x0 SHALL be consumed (handshake completes, queue pops) with regwrite=0.
REQ-013 If a push and a pop target the same register in the same cycle, the set SHALL win. This can only occur when the popped entry has already cleared.
REQ-014 stall SHALL be combinational and asserted when rs1adr or rs2adr is nonzero and its scoreboard bit is set.

Reset
REQ-015 While reset is high, regwrite, rdadr, and rd SHALL be 0 on the next edge. The scoreboard and queue SHALL be cleared.
REQ-016 While reset is high, alu_ready, ld_issue_ready, and ld_rsp_ready SHALL be 0, and inputs SHALL be ignored.
REQ-017 Loads outstanding at reset SHALL be discarded; their later responses SHALL be ignored per REQ-007.

Configuration
REQ-018 Macro WB_BYPASS_EN SHALL, when defined, add outputs byp_rs1_hit, byp_rs2_hit (1 bit each) and byp_data (32 bits).
REQ-019 byp_rsN_hit SHALL = regwrite && rdadr!=0 && rdadr==rsNadr, and byp_data SHALL = rd; stall SHALL NOT include this condition.
REQ-020 When WB_BYPASS_EN is undefined, the bypass ports SHALL be absent.
REQ-021 When WB_BYPASS_EN is undefined, stall SHALL additionally assert when regwrite && rdadr!=0 && rdadr equals a nonzero rs1adr/rs2adr.

Verification
REQ-022 Basic ALU write: alu_valid=1, alu_rdadr=5, alu_data=0x12345678 -> next cycle regwrite=1, rdadr=5, rd=0x12345678; the following idle cycle regwrite=0.
REQ-023 Load tracking: issue load to x7, then rs1adr=7 -> stall=1. Then ld_rsp_data=0xDEADBEEF -> next cycle regwrite=1, rdadr=7, rd=0xDEADBEEF, stall=0 (bypass build).
REQ-024 Collision: ALU (x3) and load response (x9) in the same cycle -> alu_ready=0 and the x9 write occurs first; the ALU is accepted the next cycle and writes x3.
REQ-025 Capacity and guards: two loads issued (x1, x2) -> ld_issue_ready=0. A load to pending x1 -> ld_issue_ready=0. alu_rdadr=1 -> alu_ready=0.
REQ-026 x0 handling: load to x0 issued and responded -> ld_rsp_ready=1 and regwrite stays 0; the scoreboard is unchanged.
REQ-027 Mid-operation reset: reset with 2 loads outstanding, then responses arrive -> ld_rsp_ready=0, regwrite=0, stall=0.

Source files
------------

// File: rtl/wb_ctrl_if.sv
// wb_ctrl_if: pipeline-side handshake and register-file write bundle for wb_ctrl.
// The master side is the pipeline (ALU, load unit, decode), the slave side is wb_ctrl.
interface wb_ctrl_if;
  // ALU result channel
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_rdadr;
  logic [31:0] alu_data;
  // Load issue channel
  logic        ld_issue_valid;
  logic        ld_issue_ready;
  logic [3:0]  ld_issue_rdadr;
  // Load response channel
  logic        ld_rsp_valid;
  logic        ld_rsp_ready;
  logic [31:0] ld_rsp_data;
  // Decode hazard query
  logic [3:0]  rs1adr;
  logic [3:0]  rs2adr;
  logic        stall;
  // Register-file write port
  logic        regwrite;
  logic [3:0]  rdadr;
  logic [31:0] rd;

  modport master (
    output alu_valid, alu_rdadr, alu_data,
    output ld_issue_valid, ld_issue_rdadr,
    output ld_rsp_valid, ld_rsp_data,
    output rs1adr, rs2adr,
    input  alu_ready, ld_issue_ready, ld_rsp_ready,
    input  stall, regwrite, rdadr, rd
  );

  modport slave (
    input  alu_valid, alu_rdadr, alu_data,
    input  ld_issue_valid, ld_issue_rdadr,
    input  ld_rsp_valid, ld_rsp_data,
    input  rs1adr, rs2adr,
    output alu_ready, ld_issue_ready, ld_rsp_ready,
    output stall, regwrite, rdadr, rd
  );
endinterface

// File: rtl/wb_ctrl.sv
// wb_ctrl: write-back arbiter between ALU results and returning loads.
// Tracks outstanding loads with a 16-bit scoreboard and a 2-entry in-order
// tag queue, gives load responses priority, and registers one register-file
// write per cycle. Writes to x0 complete their handshake but never assert regwrite.
// Optional macro WB_BYPASS_EN: adds byp_rs1_hit/byp_rs2_hit/byp_data forwarding
// outputs; without it, decode also stalls on a register being written this cycle.
module wb_ctrl (
  input  logic        clk,
  input  logic        reset,
`ifdef WB_BYPASS_EN
  output logic        byp_rs1_hit,
  output logic        byp_rs2_hit,
  output logic [31:0] byp_data,
`endif
  wb_ctrl_if.slave    bus
);

  logic [15:0] sb_q;
  logic [15:0] sb_next;
  logic [3:0]  q_mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [3:0]  head;
  logic        q_full;
  logic        q_empty;
  logic        issue_fire;
  logic        rsp_fire;
  logic        alu_fire;
  logic        regwrite_q;
  logic [3:0]  rdadr_q;
  logic [31:0] rd_q;
  logic        rs1_pend;
  logic        rs2_pend;

  assign head    = q_mem[rd_ptr];
  assign q_full  = (count == 2'd2);
  assign q_empty = (count == 2'd0);

  // Handshakes: fullness is judged on the current count, so a pop in the
  // same cycle never makes room for a push.
  assign bus.ld_issue_ready = !reset && !q_full && !sb_q[bus.ld_issue_rdadr];
  assign bus.ld_rsp_ready   = !reset && !q_empty;
  assign issue_fire         = bus.ld_issue_valid && bus.ld_issue_ready;
  assign rsp_fire           = bus.ld_rsp_valid && bus.ld_rsp_ready;
  // The ALU yields to a load response and waits while its target has a load in flight.
  assign bus.alu_ready      = !reset && !rsp_fire && !sb_q[bus.alu_rdadr];
  assign alu_fire           = bus.alu_valid && bus.alu_ready;

  assign bus.regwrite = regwrite_q;
  assign bus.rdadr    = rdadr_q;
  assign bus.rd       = rd_q;

  assign rs1_pend = (bus.rs1adr != 4'd0) && sb_q[bus.rs1adr];
  assign rs2_pend = (bus.rs2adr != 4'd0) && sb_q[bus.rs2adr];

`ifdef WB_BYPASS_EN
  // Forwarding replaces the write-in-progress stall.
  assign byp_rs1_hit = regwrite_q && (rdadr_q != 4'd0) && (rdadr_q == bus.rs1adr);
  assign byp_rs2_hit = regwrite_q && (rdadr_q != 4'd0) && (rdadr_q == bus.rs2adr);
  assign byp_data    = rd_q;
  assign bus.stall   = rs1_pend || rs2_pend;
`else
  logic wb_hazard;
  // rdadr_q is nonzero here, so an address match implies a nonzero source.
  assign wb_hazard = regwrite_q && (rdadr_q != 4'd0) &&
                     ((rdadr_q == bus.rs1adr) || (rdadr_q == bus.rs2adr));
  assign bus.stall = rs1_pend || rs2_pend || wb_hazard;
`endif

  // Scoreboard update: clear the retiring load, then set the new one so a set wins.
  always_comb begin
    // NOTE: sb_next gets a full default before any conditional write; without it the
    // partially-assigned bits would be inferred as latches.
    sb_next = sb_q;
    if (rsp_fire)   sb_next[head] = 1'b0;
    if (issue_fire) sb_next[bus.ld_issue_rdadr] = 1'b1;
    sb_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    // NOTE: all state in always_ff uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) sb_q <= '0;
    else       sb_q <= sb_next;
  end

  // Tag queue pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (issue_fire) wr_ptr <= ~wr_ptr;
      if (rsp_fire)   rd_ptr <= ~rd_ptr;
      case ({issue_fire, rsp_fire})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Tag queue storage.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is not reset; count/pointers define which entries are
    // valid, so clearing them empties the queue.
    if (issue_fire) q_mem[wr_ptr] <= bus.ld_issue_rdadr;
  end

  // Register-file write port: one registered write per accepted result, x0 suppressed.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_q <= 1'b0;
      rdadr_q    <= 4'd0;
      rd_q       <= 32'd0;
    end else if (rsp_fire) begin
      regwrite_q <= (head != 4'd0);
      if (head != 4'd0) begin
        rdadr_q <= head;
        rd_q    <= bus.ld_rsp_data;
      end
    end else if (alu_fire) begin
      regwrite_q <= (bus.alu_rdadr != 4'd0);
      if (bus.alu_rdadr != 4'd0) begin
        rdadr_q <= bus.alu_rdadr;
        rd_q    <= bus.alu_data;
      end
    end else begin
      regwrite_q <= 1'b0;
    end
  end

endmodule
